fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller for a synchronous-read instruction memory.
// It drives the word address, tracks the single outstanding read and buffers
// returned words in a 2-entry skid FIFO. Decode takes words through a
// valid/ready handshake.
//
// Ports
//   clk            : system clock, all state on the rising edge
//   rst            : synchronous active-high reset
//   imem_addr      : word address to instruction memory (the pc register)
//   imem_data      : read data, valid the cycle after the address
//   redirect_valid : load redirect_pc, flush buffered and in-flight words
//   redirect_pc    : new fetch address
//   halt           : blocks new fetches while high
//   out_valid      : out_instr/out_pc hold a fetched word
//   out_ready      : decode accepts the word this cycle
//   out_instr      : instruction word at the FIFO head
//   out_pc         : address of out_instr
//   fault          : sticky, a fetch was attempted at pc >= MEM_DEPTH
//
// fetch_sequencer_chk holds the run-time properties of the FIFO and is
// instantiated by the top; it contains no synthesizable logic.
// ---------------------------------------------------------------------------

module fetch_sequencer_chk #(
    parameter int ADDR_W = 32
) (
    input logic              clk,
    input logic              rst,
    input logic              redirect_valid,
    input logic              out_ready,
    input logic              push,
    input logic              pop,
    input logic [1:0]        count,
    input logic              out_valid,
    input logic [31:0]       out_instr,
    input logic [ADDR_W-1:0] out_pc
);

    // A push into a full FIFO without a simultaneous pop would lose a word.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == 2'd2)));

    // Occupancy can never exceed the two storage slots.
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        (count != 2'd3));

    // A stalled word must stay put until decode takes it (unless flushed).
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !redirect_valid) |=>
        (out_valid && $stable(out_pc) && $stable(out_instr)));

endmodule

module fetch_sequencer #(
    parameter int                 ADDR_W    = 32,
    parameter int                 MEM_DEPTH = 21,
    parameter logic [ADDR_W-1:0]  RESET_PC  = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              fault
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP     = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_r, state_nxt;
    logic                fault_r, fault_nxt;
    logic [ADDR_W-1:0]   pc_r, pc_nxt;
    logic                inflight_r, inflight_nxt;
    logic [ADDR_W-1:0]   inflight_pc_r, inflight_pc_nxt;

    // Shift-style skid FIFO: slot0 is always the head so the outputs come
    // straight from flops.
    logic [1:0]          count_r, count_nxt;
    logic [31:0]         slot0_instr_r, slot0_instr_nxt;
    logic [ADDR_W-1:0]   slot0_pc_r, slot0_pc_nxt;
    logic [31:0]         slot1_instr_r, slot1_instr_nxt;
    logic [ADDR_W-1:0]   slot1_pc_r, slot1_pc_nxt;

    logic                pop_s;
    logic                push_s;
    logic [2:0]          credit_s;
    logic                in_range_s;
    logic                attempt_s;
    logic                issue_s;

    // Handshake, credit and issue decisions for the current cycle.
    always_comb begin
        pop_s      = (count_r != 2'd0) & out_ready;
        push_s     = inflight_r & ~redirect_valid;
        // pop implies count >= 1, so this never underflows.
        credit_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        in_range_s = (pc_r < DEPTH_LIMIT);
        attempt_s  = (state_r == ST_RUN) & ~halt & ~redirect_valid;
        issue_s    = attempt_s & in_range_s & (credit_s <= 3'd1);
    end

    // Next-state logic: FSM, pc, in-flight tracking and FIFO contents.
    always_comb begin
        state_nxt       = state_r;
        pc_nxt          = pc_r;
        inflight_nxt    = issue_s;
        inflight_pc_nxt = inflight_pc_r;
        count_nxt       = count_r;
        slot0_instr_nxt = slot0_instr_r;
        slot0_pc_nxt    = slot0_pc_r;
        slot1_instr_nxt = slot1_instr_r;
        slot1_pc_nxt    = slot1_pc_r;

        case (state_r)
            ST_RUN: begin
                if (attempt_s && !in_range_s) begin
                    state_nxt = ST_FAULT;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_FAULT;
            end
        endcase

        if (redirect_valid) begin
            // Redirect wins: any pop this cycle completes, everything else
            // (remaining entries and the outstanding read) is dropped.
            state_nxt = ST_RUN;
            pc_nxt    = redirect_pc;
            count_nxt = 2'd0;
        end else begin
            if (issue_s) begin
                pc_nxt          = pc_r + PC_STEP;
                inflight_pc_nxt = pc_r;
            end else begin
                pc_nxt          = pc_r;
                inflight_pc_nxt = inflight_pc_r;
            end

            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_instr_nxt = imem_data;
                        slot0_pc_nxt    = inflight_pc_r;
                        count_nxt       = 2'd1;
                    end else if (count_r == 2'd1) begin
                        slot1_instr_nxt = imem_data;
                        slot1_pc_nxt    = inflight_pc_r;
                        count_nxt       = 2'd2;
                    end else begin
                        // Full: unreachable under the credit rule.
                        count_nxt = count_r;
                    end
                end
                2'b01: begin
                    slot0_instr_nxt = slot1_instr_r;
                    slot0_pc_nxt    = slot1_pc_r;
                    count_nxt       = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        slot0_instr_nxt = imem_data;
                        slot0_pc_nxt    = inflight_pc_r;
                    end else begin
                        slot0_instr_nxt = slot1_instr_r;
                        slot0_pc_nxt    = slot1_pc_r;
                        slot1_instr_nxt = imem_data;
                        slot1_pc_nxt    = inflight_pc_r;
                    end
                    count_nxt = count_r;
                end
                default: begin
                    count_nxt = count_r;
                end
            endcase
        end

        fault_nxt = (state_nxt == ST_FAULT);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            fault_r       <= 1'b0;
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
            count_r       <= 2'd0;
            slot0_instr_r <= 32'd0;
            slot0_pc_r    <= {ADDR_W{1'b0}};
            slot1_instr_r <= 32'd0;
            slot1_pc_r    <= {ADDR_W{1'b0}};
        end else begin
            state_r       <= state_nxt;
            fault_r       <= fault_nxt;
            pc_r          <= pc_nxt;
            inflight_r    <= inflight_nxt;
            inflight_pc_r <= inflight_pc_nxt;
            count_r       <= count_nxt;
            slot0_instr_r <= slot0_instr_nxt;
            slot0_pc_r    <= slot0_pc_nxt;
            slot1_instr_r <= slot1_instr_nxt;
            slot1_pc_r    <= slot1_pc_nxt;
        end
    end

    assign imem_addr = pc_r;
    assign out_valid = (count_r != 2'd0);
    assign out_instr = slot0_instr_r;
    assign out_pc    = slot0_pc_r;
    assign fault     = fault_r;

    fetch_sequencer_chk #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .out_ready      (out_ready),
        .push           (push_s),
        .pop            (pop_s),
        .count          (count_r),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A synchronous memory model returns
// 0x1000+k for word k. Each cycle's expected outputs come from a reference
// model that keeps the buffered words in a queue and the outstanding read as
// a single pending pc.
// ---------------------------------------------------------------------------

module tb_fetch_sequencer;

    localparam int DEPTH = 21;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          m_q[$];
    int          m_pend;
    int          m_pend_pc;
    logic [31:0] m_pc;
    logic        m_fault;
    int          delivered[$];

    fetch_sequencer #(
        .ADDR_W    (32),
        .MEM_DEPTH (DEPTH),
        .RESET_PC  (32'd0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    // synchronous-read instruction memory
    always @(posedge clk) begin
        if (imem_addr < 32'd21) imem_data <= 32'h0000_1000 + imem_addr;
        else                    imem_data <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic rv, input logic [31:0] rp,
                                input logic h, input logic rdy);
        int sz;
        int mpop;
        int issue_now;
        sz = m_q.size();
        mpop = (sz != 0 && rdy) ? 1 : 0;
        issue_now = 0;
        if (r) begin
            m_q.delete(); m_pend = 0; m_pc = 32'd0; m_fault = 1'b0;
        end else if (rv) begin
            m_q.delete(); m_pend = 0; m_pc = rp; m_fault = 1'b0;
        end else begin
            if (!m_fault && !h) begin
                if (m_pc >= 32'd21) m_fault = 1'b1;
                else if (sz + m_pend - mpop <= 1) issue_now = 1;
            end
            if (mpop != 0) void'(m_q.pop_front());
            if (m_pend != 0) m_q.push_back(m_pend_pc);
            m_pend = issue_now;
            if (issue_now != 0) begin
                m_pend_pc = int'(m_pc);
                m_pc = m_pc + 32'd1;
            end
        end
    endtask

    task automatic model_check();
        chk("valid", {63'd0, out_valid}, {63'd0, (m_q.size() != 0)});
        chk("imem_addr", {32'd0, imem_addr}, {32'd0, m_pc});
        chk("fault", {63'd0, fault}, {63'd0, m_fault});
        if (m_q.size() != 0) begin
            chk("out_pc", {32'd0, out_pc}, 64'(m_q[0]));
            chk("out_instr", {32'd0, out_instr}, 64'(32'h0000_1000 + m_q[0]));
        end
    endtask

    // Called at a negedge: apply inputs, advance one cycle, check at next negedge.
    task automatic step(input logic r, input logic rv, input logic [31:0] rp,
                        input logic h, input logic rdy);
        rst = r; redirect_valid = rv; redirect_pc = rp; halt = h; out_ready = rdy;
        if (!r && out_valid && rdy) delivered.push_back(int'(out_pc));
        model_update(r, rv, rp, h, rdy);
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic        ready;
        logic        ev;
        logic [31:0] epc;
        logic        ef;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        clk = 1'b0; rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        halt = 1'b0; out_ready = 1'b1;
        m_pend = 0; m_pend_pc = 0; m_pc = 32'd0; m_fault = 1'b0;

        //           rst  redir rpc    halt  ready   ev    epc    ef    eaddr
        tbl[0]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd1};
        tbl[2]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd2};
        tbl[3]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd3};
        tbl[4]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 32'd4};
        tbl[5]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 32'd5};
        tbl[6]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 32'd5};
        tbl[7]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 32'd5};
        tbl[8]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 32'd5};
        tbl[9]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 32'd6};
        tbl[10] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd5, 1'b0, 32'd7};
        tbl[11] = '{1'b0, 1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd2};
        tbl[12] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd3};
        tbl[13] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 32'd4};
        tbl[14] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd3, 1'b0, 32'd4};
        tbl[15] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd4};
        tbl[16] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd5};
        tbl[17] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 32'd6};

        @(negedge clk);

        // table-driven: reset, streaming, stall, redirect, halt
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].halt, tbl[i].ready);
            chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_addr", i), {32'd0, imem_addr}, {32'd0, tbl[i].eaddr});
            chk($sformatf("tbl%0d_fault", i), {63'd0, fault}, {63'd0, tbl[i].ef});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_pc", i), {32'd0, out_pc}, {32'd0, tbl[i].epc});
                chk($sformatf("tbl%0d_instr", i), {32'd0, out_instr},
                    {32'd0, 32'h0000_1000 + tbl[i].epc});
            end
            if (i == 0) begin
                chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
                chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
            end
        end

        // stream to the end of memory: last word is pc 20, then fault
        delivered.delete();
        step(1'b0, 1'b1, 32'd19, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("end_fault", {63'd0, fault}, 64'd1);
        chk("end_valid", {63'd0, out_valid}, 64'd0);
        chk("end_last_pc", (delivered.size() != 0) ? 64'(delivered[$]) : 64'hFFFF, 64'd20);

        // redirect out of fault
        delivered.delete();
        step(1'b0, 1'b1, 32'd2, 1'b0, 1'b1);
        chk("redir_fault_clr", {63'd0, fault}, 64'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("resume_pc0", (delivered.size() > 0) ? 64'(delivered[0]) : 64'hFFFF, 64'd2);
        chk("resume_pc1", (delivered.size() > 1) ? 64'(delivered[1]) : 64'hFFFF, 64'd3);

        // redirect while the FIFO is full
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("full_valid", {63'd0, out_valid}, 64'd1);
        step(1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("redir7_bubble", {63'd0, out_valid}, 64'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("redir7_valid", {63'd0, out_valid}, 64'd1);
        chk("redir7_pc", {32'd0, out_pc}, 64'd7);
        chk("redir7_instr", {32'd0, out_instr}, 64'h1007);

        // reset with two buffered entries
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("mrst_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_fault", {63'd0, fault}, 64'd0);
        chk("mrst_addr", {32'd0, imem_addr}, 64'd0);
        delivered.delete();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("mrst_first_pc", (delivered.size() > 0) ? 64'(delivered[0]) : 64'hFFFF, 64'd0);

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 24) == 0),
                 32'($urandom_range(0, 23)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
